// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MEM/WB control-state encoding, default
// address-error cause codes and the register-index width.
package pipe_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [4:0] EXC_ADEL_DEFAULT = 5'd4;
    localparam logic [4:0] EXC_ADES_DEFAULT = 5'd5;

    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_EXC_DRAIN = 1'b1
    } memwb_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_memwb_reg.sv
// MEM/WB pipeline register with precise address-error exception capture,
// drain-until-acknowledge control and a retired-instruction counter.
module pipe_memwb_reg
    import pipe_pkg::*;
#(
    parameter logic [4:0] ADEL_CODE = EXC_ADEL_DEFAULT,
    parameter logic [4:0] ADES_CODE = EXC_ADES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 mem_valid,
    input  logic [31:0]          mem_pc,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_alu_r,
    input  logic [31:0]          mem_ram_out,
    input  logic                 mem_m2reg,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic                 mem_rf_we,
    input  logic                 mem_ram_ena,
    input  logic                 mem_ram_wena,
    input  logic                 mem_addr_err,
    input  logic                 exc_ack,
    output logic                 wb_valid,
    output logic                 wb_rf_we,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [31:0]          wb_data,
    output logic [31:0]          wb_pc,
    output logic                 exc_req,
    output logic [31:0]          exc_epc,
    output logic [31:0]          exc_badvaddr,
    output logic [4:0]           exc_code,
    output logic                 draining,
    output logic [31:0]          retire_cnt
);

    memwb_state_e state_q, state_d;
    logic         fault;
    logic         take_exc;
    logic         load_normal;

    assign fault = mem_valid & mem_ram_ena & mem_addr_err;

    // NOTE: asynchronous active-low reset -- rst_n sits in the sensitivity list
    // so the FSM leaves EXC_DRAIN the moment reset asserts, without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Edge-rule priority: stall, then flush, then drain, then fault, then normal.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        state_d     = state_q;
        take_exc    = 1'b0;
        load_normal = 1'b0;
        if (!stall) begin
            if (flush) begin
                if (state_q == ST_EXC_DRAIN && exc_ack) state_d = ST_RUN;
            end else if (state_q == ST_EXC_DRAIN) begin
                if (exc_ack) state_d = ST_RUN;
            end else if (fault) begin
                take_exc = 1'b1;
                state_d  = ST_EXC_DRAIN;
            end else begin
                load_normal = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_rf_we     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_pc        <= '0;
            exc_req      <= 1'b0;
            exc_epc      <= '0;
            exc_badvaddr <= '0;
            exc_code     <= '0;
            retire_cnt   <= '0;
        end else begin
            // take_exc is already 0 while stalled, so a pending pulse is cleared.
            exc_req <= take_exc;
            if (!stall) begin
                wb_valid <= load_normal & mem_valid;
                wb_rf_we <= load_normal & mem_valid & mem_rf_we;
                if (load_normal) begin
                    wb_rd   <= mem_rd;
                    wb_pc   <= mem_pc;
                    wb_data <= mem_m2reg ? mem_ram_out : mem_alu_r;
                end
                if (take_exc) begin
                    exc_epc      <= mem_pc;
                    exc_badvaddr <= mem_addr;
                    exc_code     <= mem_ram_wena ? ADES_CODE : ADEL_CODE;
                end
                if (load_normal && mem_valid) retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

    assign draining = (state_q == ST_EXC_DRAIN);

endmodule : pipe_memwb_reg

// File: tb/tb_pipe_memwb_reg.sv
// Directed self-checking bench for pipe_memwb_reg: normal retirement, load and
// store address errors, stall/flush priorities, async reset and counter wrap.
module tb_pipe_memwb_reg;
    import pipe_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 stall, flush;
    logic                 mem_valid;
    logic [31:0]          mem_pc, mem_addr, mem_alu_r, mem_ram_out;
    logic                 mem_m2reg;
    logic [REG_IDX_W-1:0] mem_rd;
    logic                 mem_rf_we, mem_ram_ena, mem_ram_wena, mem_addr_err;
    logic                 exc_ack;
    logic                 wb_valid, wb_rf_we;
    logic [REG_IDX_W-1:0] wb_rd;
    logic [31:0]          wb_data, wb_pc;
    logic                 exc_req;
    logic [31:0]          exc_epc, exc_badvaddr;
    logic [4:0]           exc_code;
    logic                 draining;
    logic [31:0]          retire_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipe_memwb_reg dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .mem_valid    (mem_valid),
        .mem_pc       (mem_pc),
        .mem_addr     (mem_addr),
        .mem_alu_r    (mem_alu_r),
        .mem_ram_out  (mem_ram_out),
        .mem_m2reg    (mem_m2reg),
        .mem_rd       (mem_rd),
        .mem_rf_we    (mem_rf_we),
        .mem_ram_ena  (mem_ram_ena),
        .mem_ram_wena (mem_ram_wena),
        .mem_addr_err (mem_addr_err),
        .exc_ack      (exc_ack),
        .wb_valid     (wb_valid),
        .wb_rf_we     (wb_rf_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_pc        (wb_pc),
        .exc_req      (exc_req),
        .exc_epc      (exc_epc),
        .exc_badvaddr (exc_badvaddr),
        .exc_code     (exc_code),
        .draining     (draining),
        .retire_cnt   (retire_cnt)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One clock edge; outputs are sampled on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; mem_valid = 0; mem_pc = '0; mem_addr = '0;
        mem_alu_r = '0; mem_ram_out = '0; mem_m2reg = 0; mem_rd = '0;
        mem_rf_we = 0; mem_ram_ena = 0; mem_ram_wena = 0; mem_addr_err = 0;
        exc_ack = 0;
    endtask

    task automatic alu_instr(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] r);
        idle_inputs();
        mem_valid = 1; mem_pc = pc; mem_rd = rd; mem_alu_r = r; mem_rf_we = 1;
    endtask

    task automatic mem_fault(input logic [31:0] pc, input logic [31:0] addr, input logic store);
        idle_inputs();
        mem_valid = 1; mem_pc = pc; mem_addr = addr; mem_ram_ena = 1;
        mem_ram_wena = store; mem_addr_err = 1; mem_rf_we = ~store; mem_m2reg = ~store;
        mem_rd = 5'd10;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        #12;
        check("reset wb_valid", {31'd0, wb_valid}, 32'd0);
        check("reset wb_data", wb_data, 32'd0);
        check("reset exc_req", {31'd0, exc_req}, 32'd0);
        check("reset draining", {31'd0, draining}, 32'd0);
        check("reset retire_cnt", retire_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Normal ALU then load retirement.
        alu_instr(32'h0040_0000, 5'd8, 32'h0000_1234);
        step();
        check("alu wb_valid", {31'd0, wb_valid}, 32'd1);
        check("alu wb_rf_we", {31'd0, wb_rf_we}, 32'd1);
        check("alu wb_rd", {27'd0, wb_rd}, 32'd8);
        check("alu wb_data", wb_data, 32'h0000_1234);
        check("alu wb_pc", wb_pc, 32'h0040_0000);
        check("alu retire", retire_cnt, 32'd1);

        alu_instr(32'h0040_0004, 5'd9, 32'h0000_1000);
        mem_addr = 32'h0000_1000; mem_ram_ena = 1; mem_m2reg = 1; mem_ram_out = 32'hFFFF_FF80;
        step();
        check("load wb_data", wb_data, 32'hFFFF_FF80);
        check("load wb_rd", {27'd0, wb_rd}, 32'd9);
        check("load retire", retire_cnt, 32'd2);

        // Misaligned load, then drain.
        mem_fault(32'h0040_0010, 32'h0000_1001, 1'b0);
        step();
        check("adel exc_req", {31'd0, exc_req}, 32'd1);
        check("adel epc", exc_epc, 32'h0040_0010);
        check("adel badvaddr", exc_badvaddr, 32'h0000_1001);
        check("adel code", {27'd0, exc_code}, 32'd4);
        check("adel wb_rf_we", {31'd0, wb_rf_we}, 32'd0);
        check("adel wb_valid", {31'd0, wb_valid}, 32'd0);
        check("adel draining", {31'd0, draining}, 32'd1);
        check("adel retire", retire_cnt, 32'd2);

        alu_instr(32'h0040_0014, 5'd11, 32'h0000_00AA);
        step();
        check("drain exc_req pulse", {31'd0, exc_req}, 32'd0);
        check("drain kill wb_valid", {31'd0, wb_valid}, 32'd0);
        check("drain still", {31'd0, draining}, 32'd1);

        exc_ack = 1;
        step();
        check("ack kill wb_valid", {31'd0, wb_valid}, 32'd0);
        check("ack draining", {31'd0, draining}, 32'd0);
        check("ack retire", retire_cnt, 32'd2);

        alu_instr(32'h0040_0018, 5'd12, 32'h0000_0055);
        step();
        check("post-ack wb_valid", {31'd0, wb_valid}, 32'd1);
        check("post-ack wb_data", wb_data, 32'h0000_0055);
        check("post-ack retire", retire_cnt, 32'd3);

        // Misaligned store; stall in the exc_req cycle clears the pulse.
        mem_fault(32'h0040_0020, 32'h0000_2002, 1'b1);
        step();
        check("ades exc_req", {31'd0, exc_req}, 32'd1);
        check("ades code", {27'd0, exc_code}, 32'd5);
        check("ades badvaddr", exc_badvaddr, 32'h0000_2002);
        check("ades retire", retire_cnt, 32'd3);
        idle_inputs();
        stall = 1;
        step();
        check("stall clears exc_req", {31'd0, exc_req}, 32'd0);
        check("stall holds drain", {31'd0, draining}, 32'd1);
        stall = 0;
        step();
        check("no reissue exc_req", {31'd0, exc_req}, 32'd0);
        exc_ack = 1;
        step();
        check("ades ack draining", {31'd0, draining}, 32'd0);

        // Stall on a faulting cycle defers detection.
        mem_fault(32'h0040_0030, 32'h0000_3003, 1'b0);
        stall = 1;
        step();
        check("stalled fault exc_req", {31'd0, exc_req}, 32'd0);
        check("stalled fault draining", {31'd0, draining}, 32'd0);
        check("stalled fault epc", exc_epc, 32'h0040_0020);
        stall = 0;
        step();
        check("unstalled fault exc_req", {31'd0, exc_req}, 32'd1);
        check("unstalled fault epc", exc_epc, 32'h0040_0030);
        check("unstalled fault code", {27'd0, exc_code}, 32'd4);
        idle_inputs();
        exc_ack = 1;
        step();
        check("stall case ack", {31'd0, draining}, 32'd0);

        // Flush with fault: bubble only.
        mem_fault(32'h0040_0040, 32'h0000_4001, 1'b0);
        flush = 1;
        step();
        check("flush exc_req", {31'd0, exc_req}, 32'd0);
        check("flush draining", {31'd0, draining}, 32'd0);
        check("flush wb_valid", {31'd0, wb_valid}, 32'd0);
        check("flush epc held", exc_epc, 32'h0040_0030);

        // Fault while draining is ignored.
        mem_fault(32'h0040_0050, 32'h0000_5001, 1'b0);
        step();
        check("first fault epc", exc_epc, 32'h0040_0050);
        mem_fault(32'h0040_0060, 32'h0000_6002, 1'b1);
        step();
        check("drain fault exc_req", {31'd0, exc_req}, 32'd0);
        check("drain fault epc", exc_epc, 32'h0040_0050);
        check("drain fault badvaddr", exc_badvaddr, 32'h0000_5001);
        check("drain fault code", {27'd0, exc_code}, 32'd4);
        check("drain fault draining", {31'd0, draining}, 32'd1);

        // Asynchronous reset mid-drain, away from any clock edge.
        idle_inputs();
        #2 rst_n = 0;
        #1;
        check("async rst draining", {31'd0, draining}, 32'd0);
        check("async rst epc", exc_epc, 32'd0);
        check("async rst code", {27'd0, exc_code}, 32'd0);
        check("async rst wb_data", wb_data, 32'd0);
        check("async rst retire", retire_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Counter wrap from an all-ones preload.
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1 release dut.retire_cnt;
        #1;
        check("wrap preload", retire_cnt, 32'hFFFF_FFFF);
        alu_instr(32'h0040_0070, 5'd3, 32'h0000_0777);
        step();
        check("wrap retire", retire_cnt, 32'd0);
        check("wrap wb_valid", {31'd0, wb_valid}, 32'd1);

        idle_inputs();
        step();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_pipe_memwb_reg

// File: doc/pipe_memwb_reg.md
# pipe_memwb_reg

MEM/WB pipeline register for the five-stage pipeline, directly downstream of the memory stage. It latches the memory stage's result (load data or ALU result), destination register and write enable, and honours stall and flush. It also converts the memory stage's address-error flag into a precise exception: capture EPC/BadVAddr/cause, kill the faulting instruction, and drain until the exception is acknowledged. A 32-bit retired-instruction counter is included.

## Interface
Parameters:
- ADEL_CODE, 5'd4, cause code for a misaligned load.
- ADES_CODE, 5'd5, cause code for a misaligned store.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold all registers; no capture, no exception detection.
- flush  in  1  kill the incoming instruction (bubble into WB).
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_pc  in  32  PC of the MEM instruction.
- mem_addr  in  32  effective data address.
- mem_alu_r  in  32  ALU result.
- mem_ram_out  in  32  aligned/extended load data from the memory stage.
- mem_m2reg  in  1  1 = write load data, 0 = write ALU result.
- mem_rd  in  5  destination register.
- mem_rf_we  in  1  register-file write request.
- mem_ram_ena  in  1  instruction is a memory access.
- mem_ram_wena  in  1  access is a store.
- mem_addr_err  in  1  address-error flag from the memory stage.
- exc_ack  in  1  exception handler redirect has taken effect.
- wb_valid  out  1  WB holds a live instruction.
- wb_rf_we  out  1  register-file write enable.
- wb_rd  out  5  destination register.
- wb_data  out  32  write-back data.
- wb_pc  out  32  PC of WB instruction.
- exc_req  out  1  one-cycle exception request pulse.
- exc_epc  out  32  PC of the faulting instruction.
- exc_badvaddr  out  32  faulting address.
- exc_code  out  5  cause code.
- draining  out  1  high while in EXC_DRAIN.
- retire_cnt  out  32  count of instructions retired with wb_valid.

## Operation
- States: RUN, EXC_DRAIN. Reset → RUN.
- fault = mem_valid & mem_ram_ena & mem_addr_err.
- Per edge, first matching rule wins:
  1. stall=1: hold every register, including state. exc_req forced 0.
  2. flush=1: wb_valid, wb_rf_we ← 0. No fault detection. State unchanged, except EXC_DRAIN & exc_ack → RUN.
  3. EXC_DRAIN: incoming instruction is killed (wb_valid, wb_rf_we ← 0). exc_ack → RUN. A fault in this cycle is ignored.
  4. RUN & fault: kill the instruction. Capture exc_epc←mem_pc and exc_badvaddr←mem_addr. exc_code ← ADES_CODE if mem_ram_wena, else ADEL_CODE. exc_req ← 1; state → EXC_DRAIN.
  5. RUN, normal: wb_valid←mem_valid; wb_rf_we←mem_valid & mem_rf_we; wb_rd←mem_rd; wb_pc←mem_pc; wb_data←mem_m2reg ? mem_ram_out : mem_alu_r.
- exc_ack in RUN is ignored.
- exc_* registers hold their value until the next fault.
- wb_rd, wb_data and wb_pc may update on killed cycles; consumers qualify them with wb_rf_we/wb_valid.
- retire_cnt += 1 on every non-stalled edge that loads wb_valid=1. Wraps modulo 2^32.

## Timing
- All outputs are registered; latency MEM→WB is 1 cycle.
- exc_req is high for exactly one cycle: the cycle after the capturing edge. A stall in that cycle clears it and does not re-issue it.
- Reset values: all outputs 0, state RUN, draining 0, retire_cnt 0. Reset asserted mid-drain returns to RUN immediately.
- Minimum drain is one cycle: the earliest exc_ack that takes effect is sampled on the edge after exc_req rises.
- draining = (state == EXC_DRAIN), registered.

## Structure
- Shared package pipe_pkg:
  - state encoding (RUN=1'b0, EXC_DRAIN=1'b1);
  - default exception cause constants (4, 5);
  - register-index width 5.
- Single flat module; no sub-module is warranted. The retire counter is inline.

## Test plan
- Normal flow: ALU instruction with rd=8, alu_r=0x1234, m2reg=0 → next cycle wb_rf_we=1, wb_rd=8, wb_data=0x1234, retire_cnt=1. Then a load with ram_out=0xFFFFFF80, m2reg=1 → wb_data=0xFFFFFF80, retire_cnt=2.
- Misaligned load: pc=0x400010, addr=0x1001, addr_err=1, wena=0 → exc_req one cycle; epc=0x400010, badvaddr=0x1001, code=4, wb_rf_we=0, draining=1. A following valid ALU instruction is killed. exc_ack → RUN, and the next instruction retires.
- Misaligned store: addr=0x2002, wena=1 → code=5, no retire.
- Priorities:
  - stall high on a faulting cycle → no exc_req; fault taken on the first unstalled edge.
  - flush with fault → bubble only, state stays RUN.
  - fault while draining → ignored, exc_* unchanged.
- Reset: assert rst_n=0 asynchronously mid-drain → all outputs 0, state RUN without a clock edge.
- Counter wrap: preload via 0xFFFFFFFF retirements (or force) → next retirement gives retire_cnt=0.
